// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its downstream stages.
package fir_pkg;

   localparam int FIR_OUT_W  = 9;
   localparam int FIR_ORDER  = 4;
   // Samples still carrying pipeline-fill garbage after reset.
   localparam int FIR_WARMUP = FIR_ORDER + 1;

   typedef logic [FIR_OUT_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous FIFO with first-word fall-through head register.
module fir_sync_fifo import fir_pkg::*; #(
   parameter int DATA_W = FIR_OUT_W,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic [DATA_W-1:0]        i_din,
   input  logic                     i_pop,
   output logic [DATA_W-1:0]        o_dout,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic [DATA_W-1:0] r_dout;

   logic              w_pop;
   logic              w_push;
   logic              w_full;
   logic [AW-1:0]     w_rd_nxt;
   logic [LW-1:0]     w_level_nxt;
   logic [LW-1:0]     w_remain;

   assign w_full      = (r_level == LW'(DEPTH));
   assign w_pop       = i_pop && (r_level != '0);
   assign w_push      = i_push && (!w_full || w_pop);
   assign w_rd_nxt    = r_rd_ptr + AW'(w_pop);
   assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
   assign w_remain    = r_level - LW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

   // Head register preloads the next oldest entry, or the incoming sample
   // when nothing older remains, so the output is valid one edge after a push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_dout   <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= w_rd_nxt;
         r_level  <= w_level_nxt;
         if (w_level_nxt != '0) begin
            r_dout <= (w_remain == '0) ? i_din : r_mem[w_rd_nxt];
         end
      end
   end

   assign o_dout  = r_dout;
   assign o_level = r_level;
   assign o_full  = w_full;
   assign o_empty = (r_level == '0);

endmodule

// File: rtl/fir_decim_buffer.sv
// Post-FIR stage: drops warm-up samples, decimates by DECIM and buffers
// kept samples in a FIFO behind a valid/ready interface.
module fir_decim_buffer import fir_pkg::*; #(
   parameter int DATA_W = FIR_OUT_W,
   parameter int DECIM  = 2,
   parameter int DEPTH  = 8,
   parameter int WARMUP = FIR_WARMUP
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     sample_en,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int WW = $clog2(WARMUP + 2);
   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [WW-1:0] WARM_END = WW'(WARMUP);
   localparam logic [PW-1:0] PH_LAST  = PW'(DECIM - 1);

   logic [WW-1:0] r_warm;
   logic [PW-1:0] r_phase;
   logic          r_overflow;

   logic          w_warm_done;
   logic          w_keep;
   logic          w_drop;
   logic          w_full;
   logic          w_empty;

   assign w_warm_done = (r_warm == WARM_END);
   assign w_keep      = sample_en && w_warm_done && (r_phase == '0);
   // A full FIFO still accepts the sample if the consumer pops this edge.
   assign w_drop      = w_keep && w_full && !(out_ready && !w_empty);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_warm     <= '0;
         r_phase    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (sample_en) begin
            if (!w_warm_done) begin
               r_warm <= r_warm + WW'(1);
            end else begin
               r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + PW'(1);
            end
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_ovf) begin
            r_overflow <= 1'b0;
         end
      end
   end

   fir_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_keep),
      .i_din   (in_data),
      .i_pop   (out_ready),
      .o_dout  (out_data),
      .o_level (level),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign out_valid = ~w_empty;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_fir_decim_buffer.sv
// Directed bench for fir_decim_buffer with a queue-based reference model.
module tb_fir_decim_buffer;

   localparam int DATA_W = 9;
   localparam int DECIM  = 2;
   localparam int DEPTH  = 8;
   localparam int WARMUP = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [DATA_W-1:0] in_data = '0;
   logic              sample_en = 1'b0;
   logic              out_ready = 1'b0;
   logic              clr_ovf = 1'b0;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic [3:0]        level;
   logic              overflow;

   int n_chk  = 0;
   int n_fail = 0;

   fir_decim_buffer #(
      .DATA_W (DATA_W),
      .DECIM  (DECIM),
      .DEPTH  (DEPTH),
      .WARMUP (WARMUP)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .sample_en (sample_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a queue of kept samples plus warm-up and phase counts.
   int                m_q[$];
   int                m_warm  = 0;
   int                m_phase = 0;
   bit                m_ovf   = 1'b0;
   int                m_head  = 0;
   bit                m_keep, m_drop, m_pop;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_warm  = 0;
         m_phase = 0;
         m_ovf   = 1'b0;
         m_head  = 0;
      end else begin
         m_keep = 1'b0;
         m_drop = 1'b0;
         m_pop  = (m_q.size() != 0) && out_ready;
         if (sample_en) begin
            if (m_warm < WARMUP) begin
               m_warm++;
            end else begin
               m_keep  = (m_phase == 0);
               m_phase = (m_phase + 1) % DECIM;
            end
         end
         if (m_pop) void'(m_q.pop_front());
         if (m_keep) begin
            if (m_q.size() < DEPTH) m_q.push_back(int'(in_data));
            else m_drop = 1'b1;
         end
         if (m_drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         if (m_q.size() != 0) m_head = m_q[0];
      end
   end

   always @(negedge clk) begin
      chk("model_valid", out_valid, (m_q.size() != 0));
      chk("model_level", level, m_q.size());
      chk("model_data", out_data, m_head);
      chk("model_ovf", overflow, m_ovf);
   end

   task automatic step(input logic en, input logic [DATA_W-1:0] d,
                       input logic rdy, input logic clr);
      sample_en = en;
      in_data   = d;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sample_en = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int obs[$];
      int exp_w[4] = '{6, 8, 10, 12};
      logic [DATA_W-1:0] first_d, last_d;

      do_reset();
      chk("reset_valid", out_valid, 0);
      chk("reset_level", level, 0);
      chk("reset_data", out_data, 0);
      chk("reset_ovf", overflow, 0);

      // Warm-up and decimation with a consumer that is always ready.
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, DATA_W'(i), 1'b1, 1'b0);
         if (out_valid) obs.push_back(int'(out_data));
      end
      chk("warm_count", obs.size(), 4);
      for (int k = 0; k < 4 && k < obs.size(); k++) chk("warm_seq", obs[k], exp_w[k]);

      // One-cycle latency into an empty FIFO.
      do_reset();
      for (int i = 0; i < WARMUP; i++) step(1'b1, 9'h0FF, 1'b0, 1'b0);
      chk("pre_latency_valid", out_valid, 0);
      step(1'b1, 9'h1A5, 1'b0, 1'b0);
      chk("lat_valid", out_valid, 1);
      chk("lat_data", out_data, 9'h1A5);
      chk("lat_level", level, 1);

      // Backpressure: nine kept samples into eight slots.
      do_reset();
      for (int i = 0; i < WARMUP; i++) step(1'b1, 9'h000, 1'b0, 1'b0);
      for (int i = 0; i < 18; i++) step(1'b1, DATA_W'(9'h010 + i), 1'b0, 1'b0);
      chk("bp_level", level, 8);
      chk("bp_ovf", overflow, 1);
      for (int k = 0; k < 8; k++) begin
         chk("bp_drain", out_data, 9'h010 + 2 * k);
         step(1'b0, 9'h000, 1'b1, 1'b0);
      end
      chk("bp_empty_level", level, 0);
      chk("bp_empty_valid", out_valid, 0);
      chk("bp_hold_data", out_data, 9'h01E);
      chk("bp_ovf_sticky", overflow, 1);

      step(1'b0, 9'h000, 1'b0, 1'b1);
      chk("clr_alone", overflow, 0);

      // Refill, then clear colliding with a dropped push.
      for (int i = 0; i < 16; i++) step(1'b1, DATA_W'(9'h030 + i), 1'b0, 1'b0);
      chk("refill_level", level, 8);
      step(1'b1, 9'h07F, 1'b0, 1'b1);
      chk("clr_collide", overflow, 1);
      chk("clr_collide_level", level, 8);
      step(1'b1, 9'h000, 1'b0, 1'b1);
      chk("clr_again", overflow, 0);

      // Full FIFO with simultaneous pop and push.
      step(1'b1, 9'h055, 1'b1, 1'b0);
      chk("fullpp_level", level, 8);
      chk("fullpp_ovf", overflow, 0);
      first_d = out_data;
      last_d  = '0;
      for (int k = 0; k < 8; k++) begin
         last_d = out_data;
         step(1'b0, 9'h000, 1'b1, 1'b0);
      end
      chk("fullpp_first", first_d, 9'h032);
      chk("fullpp_last", last_d, 9'h055);
      chk("fullpp_empty", out_valid, 0);

      // Asynchronous reset while holding data.
      for (int i = 0; i < 10; i++) step(1'b1, DATA_W'(9'h040 + i), 1'b0, 1'b0);
      chk("mid_level", level, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", out_valid, 0);
      chk("async_data", out_data, 0);
      chk("async_level", level, 0);
      chk("async_ovf", overflow, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      for (int i = 0; i < WARMUP; i++) step(1'b1, DATA_W'(9'h060 + i), 1'b1, 1'b0);
      chk("rewarm_valid", out_valid, 0);
      chk("rewarm_level", level, 0);
      step(1'b1, 9'h0AB, 1'b0, 1'b0);
      chk("rewarm_keep_valid", out_valid, 1);
      chk("rewarm_keep_data", out_data, 9'h0AB);
      chk("rewarm_keep_level", level, 1);

      repeat (3) step(1'b0, 9'h000, 1'b1, 1'b0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_decim_buffer.md
# fir_decim_buffer

Downstream stage of the pipelined FIR filter. Consumes the filter's 9-bit output sample stream and discards the pipeline-fill samples after reset. Decimates the stream by a fixed factor and buffers the kept samples in a small FIFO. Presents them on a valid/ready interface to the next consumer.

## Interface

Parameters:
- DATA_W, 9, sample width; matches the FIR output width.
- DECIM, 2, decimation factor (≥1); keep one of every DECIM post-warm-up samples.
- DEPTH, 8, FIFO depth in samples (power of two, ≥2).
- WARMUP, 5, number of sample_en cycles to discard after reset; equals FIR order+1.

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, DATA_W, FIR output sample (unsigned).
- sample_en, in, 1, in_data is a new sample this cycle.
- out_data, out, DATA_W, FIFO head sample.
- out_valid, out, 1, out_data holds a buffered sample.
- out_ready, in, 1, consumer accepts out_data this cycle.
- level, out, $clog2(DEPTH)+1, current FIFO occupancy (0..DEPTH).
- overflow, out, 1, sticky: a kept sample was dropped because the FIFO was full.
- clr_ovf, in, 1, synchronous clear of overflow.

## Operation

- Reset (rst_n low, asynchronous) sets the following to 0:
  - out_valid, out_data, level, overflow
  - warm-up counter, decimation phase, FIFO pointers
- Warm-up: the first WARMUP sample_en cycles after reset are discarded. No effect on the FIFO or phase.
- Decimation: after warm-up, each sample_en cycle evaluates phase.
  - phase==0 means the sample is kept.
  - phase increments modulo DECIM on every post-warm-up sample_en.
  - DECIM=1 keeps every sample.
- Push: a kept sample is written if the FIFO has space after this cycle's pop.
  - When full and popping in the same cycle, the push is accepted and level stays DEPTH.
  - When full and not popping, the sample is dropped, overflow is set to 1, and phase still advances.
- Pop: occurs when out_valid && out_ready. Popping with out_valid low is ignored.
- out_valid = (level != 0). out_data is the oldest sample (first-word fall-through). out_data holds its last value when empty.
- Pointers wrap modulo DEPTH. level tracks push-minus-pop exactly and never exceeds DEPTH.
- clr_ovf clears overflow. If an overflow event occurs in the same cycle, set wins and overflow stays 1.
- sample_en low: no warm-up, phase or push activity. Pops continue.
- in_data is passed unmodified; no arithmetic on samples.
- Reset mid-operation discards buffered data and restarts warm-up.

## Timing

- Sample with sample_en at edge k, kept and FIFO empty: out_valid=1 and out_data=sample after edge k (1-cycle latency).
- Pop at edge k: the next entry appears after edge k; out_valid drops after edge k if level becomes 0.
- level and overflow are registered and update on the same edge as the push/pop.
- out_data must not change while out_valid && !out_ready.
- First keepable sample is the (WARMUP+1)-th sample_en after reset deassertion.

## Structure

- fir_pkg holds:
  - FIR_OUT_W = 9
  - typedef fir_sample_t (logic [FIR_OUT_W-1:0])
  - the default WARMUP relation (ORDER+1), shared with the FIR stage
- One sub-module: fir_sync_fifo (DATA_W, DEPTH), with push/pop/full/empty/level and first-word fall-through read.
- Warm-up counter, phase counter and overflow logic live in the top.

## Test plan

- Warm-up: reset, then sample_en every cycle with in_data=1,2,3,… (DECIM=2, WARMUP=5, out_ready=1) -> outputs are 6,8,10,…; nothing before 6.
- Latency: empty FIFO, keep sample 0x1A5 at edge k -> out_valid=1, out_data=0x1A5 after edge k; level=1.
- Backpressure/overflow: out_ready=0, push 9 kept samples into DEPTH=8 -> level=8, overflow=1, 9th sample lost. Then drain 8 -> order preserved, level=0, out_valid=0.
- Full with simultaneous pop and push: level=8, out_ready=1, kept sample 0x055 -> level stays 8, overflow stays 0, 0x055 appears last.
- clr_ovf collision: overflow=1, assert clr_ovf alone -> 0. Assert clr_ovf together with a dropped push -> remains 1.
- Reset mid-stream: level=5, assert rst_n low asynchronously between edges -> all outputs 0 immediately. After release, warm-up discards 5 samples again.
